// File: rtl/bin_maxpool_2x2.sv
`default_nettype none
// ============================================================================
// Module      : bin_maxpool_2x2
// Description : 2x2 stride-2 binary max pool (4-input OR) over a list of
//               binary feature maps read from SRAM. Each row is one word and
//               bit c is column c. Pooled rows are written to the output SRAM.
//               The list ends at the 16'h00FF sentinel header.
//               Optional build macro: BINPOOL_HEADER_EN. When it is defined,
//               a header word {P} is written before each matrix's pooled
//               rows, and the sentinel is written after the last matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_maxpool_2x2 #(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] OUT_BASE = '0
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_RDA  = 3'd2;
    localparam logic [2:0] S_RDB  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [DATA_W-1:0] SENTINEL = DATA_W'(16'h00FF);
    localparam logic [4:0]        MAX_DIM  = 5'(DATA_W);

    logic [2:0]        state_q,    state_d;
    logic              hdr_wait_q, hdr_wait_d;   // header address presented, data not back yet
    logic              prime_q,    prime_d;      // first RDA cycle of a matrix: pipeline fill
    logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
    logic [4:0]        dim_q,      dim_d;
    logic [3:0]        pairs_q,    pairs_d;      // row pairs still to pool, current one included
    logic [DATA_W-1:0] row_a_q,    row_a_d;
    logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;
    logic              wr_en_q,    wr_en_d;
    logic              busy_q,     busy_d;

    logic              hdr_is_sentinel;
    logic [4:0]        hdr_dim;
    logic [3:0]        hdr_pool;
    logic [ADDR_W-1:0] hdr_next;
    logic [ADDR_W-1:0] mat_next;
    logic [DATA_W-1:0] col_mask;
    logic [DATA_W-1:0] row_a_m;
    logic [DATA_W-1:0] row_b_m;
    logic [DATA_W-1:0] pool_word;

    assign hdr_is_sentinel = (sram_dut_read_data == SENTINEL);
    assign hdr_dim         = (sram_dut_read_data[4:0] > MAX_DIM) ? MAX_DIM : sram_dut_read_data[4:0];
    assign hdr_pool        = hdr_dim[4:1];
    assign hdr_next        = hdr_addr_q + ADDR_W'(1) + ADDR_W'(hdr_dim);
    assign mat_next        = hdr_addr_q + ADDR_W'(1) + ADDR_W'(dim_q);

    assign row_a_m = row_a_q & col_mask;
    assign row_b_m = sram_dut_read_data & col_mask;

    generate
        for (genvar c = 0; c < DATA_W; c++) begin : g_mask
            assign col_mask[c] = (c < int'(dim_q));
        end
        for (genvar j = 0; j < DATA_W; j++) begin : g_pool
            if (j < DATA_W / 2) begin : g_live
                assign pool_word[j] = (j < int'(dim_q[4:1])) &
                                      (row_a_m[2*j] | row_a_m[2*j+1] |
                                       row_b_m[2*j] | row_b_m[2*j+1]);
            end else begin : g_zero
                assign pool_word[j] = 1'b0;
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (dut_run) state_d = S_HDR;
            S_HDR: begin
                if (!hdr_wait_q) begin
                    if (hdr_is_sentinel)     state_d = S_DONE;
                    else if (hdr_pool != 0)  state_d = S_RDA;
                end
            end
            S_RDA:  if (!prime_q) state_d = S_RDB;
            S_RDB:  state_d = (pairs_q == 4'd1) ? S_HDR : S_RDA;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output register updates for each state
    always_comb begin
        hdr_wait_d = hdr_wait_q;
        prime_d    = prime_q;
        hdr_addr_d = hdr_addr_q;
        dim_d      = dim_q;
        pairs_d    = pairs_q;
        row_a_d    = row_a_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        busy_d     = busy_q;
        if (wr_en_q) wr_addr_d = wr_addr_q + ADDR_W'(1);
        case (state_q)
            S_IDLE: begin
                rd_addr_d  = '0;
                hdr_addr_d = '0;
                if (dut_run) begin
                    busy_d     = 1'b1;
                    wr_addr_d  = OUT_BASE;
                    hdr_wait_d = 1'b1;
                end
            end
            S_HDR: begin
                if (hdr_wait_q) begin
                    hdr_wait_d = 1'b0;
                end else begin
`ifdef BINPOOL_HEADER_EN
                    wr_data_d = hdr_is_sentinel ? SENTINEL : DATA_W'(hdr_pool);
                    wr_en_d   = 1'b1;
`endif
                    if (!hdr_is_sentinel) begin
                        dim_d   = hdr_dim;
                        pairs_d = hdr_pool;
                        if (hdr_pool == 4'd0) begin
                            // Degenerate matrix: skip straight to the next header
                            hdr_addr_d = hdr_next;
                            rd_addr_d  = hdr_next;
                            hdr_wait_d = 1'b1;
                        end else begin
                            rd_addr_d = hdr_addr_q + ADDR_W'(1);
                            prime_d   = 1'b1;
                        end
                    end
                end
            end
            S_RDA: begin
                // Reads run back to back; a read past the last row is harmless
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                if (prime_q) prime_d = 1'b0;
                else         row_a_d = sram_dut_read_data;
            end
            S_RDB: begin
                wr_data_d = pool_word;
                wr_en_d   = 1'b1;
                pairs_d   = pairs_q - 4'd1;
                if (pairs_q == 4'd1) begin
                    hdr_addr_d = mat_next;
                    rd_addr_d  = mat_next;
                    hdr_wait_d = 1'b1;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            S_DONE: busy_d = 1'b0;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            hdr_wait_q <= 1'b0;
            prime_q    <= 1'b0;
            hdr_addr_q <= '0;
            dim_q      <= '0;
            pairs_q    <= '0;
            row_a_q    <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= OUT_BASE;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            hdr_wait_q <= hdr_wait_d;
            prime_q    <= prime_d;
            hdr_addr_q <= hdr_addr_d;
            dim_q      <= dim_d;
            pairs_q    <= pairs_d;
            row_a_q    <= row_a_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
        end
    end

    assign dut_busy               = busy_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_sram_write_address = wr_addr_q;
    assign dut_sram_write_data    = wr_data_q;
    assign dut_sram_write_enable  = wr_en_q;

endmodule
`default_nettype wire
